// File: rtl/cpu_flags_pkg.sv
// rtl/cpu_flags_pkg.sv - shared ALU op encoding and condition-flag record
package cpu_flags_pkg;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_LOGIC = 2'b10,
    ALU_CMP   = 2'b11
  } aluop_t;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '0;

endpackage

// File: rtl/flag_unit_if.sv
// rtl/flag_unit_if.sv - ALU-side operand/control bundle and flag/stack status outputs
interface flag_unit_if #(parameter int WIDTH = 32);
  import cpu_flags_pkg::*;

  aluop_t           aluOp;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             setF;
  logic             stall;
  logic             flush;
  logic             push;
  logic             pop;
  logic             Nflag;
  logic             Zflag;
  logic             Vflag;
  logic             Cflag;
  logic             stkFull;
  logic             stkEmpty;
  logic             stkErr;

  modport master (
    output aluOp, opA, opB, res, cout, setF, stall, flush, push, pop,
    input  Nflag, Zflag, Vflag, Cflag, stkFull, stkEmpty, stkErr
  );

  modport slave (
    input  aluOp, opA, opB, res, cout, setF, stall, flush, push, pop,
    output Nflag, Zflag, Vflag, Cflag, stkFull, stkEmpty, stkErr
  );

endinterface

// File: rtl/flag_stack.sv
// rtl/flag_stack.sv - DEPTH-entry LIFO of saved flag sets with count, full/empty and sticky error
module flag_stack
  import cpu_flags_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   full,
  output logic   empty,
  output logic   err,
  output logic   pop_ok
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  flags_t        mem [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic          bad_op;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // A simultaneous push and pop cancel out entirely, including the error check.
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign bad_op  = (push & ~pop & full) | (pop & ~push & empty);
  assign pop_ok  = do_pop;

  assign wr_idx  = AW'(count);
  assign rd_idx  = AW'(count - CW'(1));
  assign top     = empty ? FLAGS_CLEAR : mem[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (do_push)
        count <= count + CW'(1);
      else if (do_pop)
        count <= count - CW'(1);
      if (bad_op)
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= din;
  end

endmodule

// File: rtl/flag_unit.sv
// rtl/flag_unit.sv - N/Z/V/C flag register with save/restore stack; FLAG_FWD_EN enables same-cycle flag bypass
module flag_unit
  import cpu_flags_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  flag_unit_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  flags_t flags_q;
  flags_t new_f;
  flags_t out_f;
  flags_t stk_top;
  logic   active;
  logic   stk_pop_ok;
  logic   stk_full;
  logic   stk_empty;
  logic   stk_err;
  logic   unused_ops;

  assign active = ~bus.flush & ~bus.stall;

  // Only the sign bits of the operands matter for overflow detection.
  assign unused_ops = ^{bus.opA[MSB-1:0], bus.opB[MSB-1:0]};

  always_comb begin
    new_f   = flags_q;
    new_f.n = bus.res[MSB];
    new_f.z = (bus.res == '0);
    case (bus.aluOp)
      ALU_ADD: begin
        new_f.v = (bus.opA[MSB] == bus.opB[MSB]) && (bus.res[MSB] != bus.opA[MSB]);
        new_f.c = bus.cout;
      end
      ALU_SUB, ALU_CMP: begin
        new_f.v = (bus.opA[MSB] != bus.opB[MSB]) && (bus.res[MSB] != bus.opA[MSB]);
        new_f.c = bus.cout;
      end
      default: ;
    endcase
  end

  flag_stack #(.DEPTH(DEPTH)) u_stack (
    .clk    (clk),
    .rst    (rst),
    .push   (active & bus.push),
    .pop    (active & bus.pop),
    .din    (flags_q),
    .top    (stk_top),
    .full   (stk_full),
    .empty  (stk_empty),
    .err    (stk_err),
    .pop_ok (stk_pop_ok)
  );

  // Any pop request, even a rejected one, blocks setF in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= FLAGS_CLEAR;
    end else if (active) begin
      if (stk_pop_ok)
        flags_q <= stk_top;
      else if (bus.setF && !bus.pop)
        flags_q <= new_f;
    end
  end

`ifdef FLAG_FWD_EN
  assign out_f = (bus.setF && active && !bus.pop) ? new_f : flags_q;
`else
  assign out_f = flags_q;
`endif

  assign bus.Nflag    = out_f.n;
  assign bus.Zflag    = out_f.z;
  assign bus.Vflag    = out_f.v;
  assign bus.Cflag    = out_f.c;
  assign bus.stkFull  = stk_full;
  assign bus.stkEmpty = stk_empty;
  assign bus.stkErr   = stk_err;

endmodule

// File: tb/tb_flag_unit.sv
// tb/tb_flag_unit.sv - directed self-checking bench for flag_unit (WIDTH=8, DEPTH=4)
module tb_flag_unit;
  import cpu_flags_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  flag_unit_if #(.WIDTH(8)) bus ();

  flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  wire [3:0] nzvc = {bus.Nflag, bus.Zflag, bus.Vflag, bus.Cflag};
  wire [2:0] stk  = {bus.stkFull, bus.stkEmpty, bus.stkErr};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic op(input aluop_t o, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] r, input logic co);
    bus.aluOp = o;
    bus.opA   = a;
    bus.opB   = b;
    bus.res   = r;
    bus.cout  = co;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.setF  = 1'b0;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.setF = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    op(ALU_ADD, 8'h00, 8'h00, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_nzvc", 8'(nzvc), 8'b0000);
    chk("reset_stk",  8'(stk),  8'b010);

`ifdef FLAG_FWD_EN
    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1;
    #1;
    chk("fwd_add_pre_edge", 8'(nzvc), 8'b1010);
`endif

    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1; step();
    chk("add_overflow", 8'(nzvc), 8'b1010);

    op(ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1); bus.setF = 1'b1; step();
    chk("sub_zero", 8'(nzvc), 8'b0101);

    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1; bus.stall = 1'b1; step();
    chk("stall_hold", 8'(nzvc), 8'b0101);

    op(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b1); bus.setF = 1'b1; step();
    chk("sub_overflow", 8'(nzvc), 8'b0011);

    op(ALU_LOGIC, 8'h0F, 8'hF0, 8'h00, 1'b0); bus.setF = 1'b1; step();
    chk("logic_keeps_vc", 8'(nzvc), 8'b0111);

    op(ALU_LOGIC, 8'hFF, 8'hFF, 8'h80, 1'b0); bus.setF = 1'b1; bus.flush = 1'b1; bus.push = 1'b1; step();
    chk("flush_flags", 8'(nzvc), 8'b0111);
    chk("flush_stk",   8'(stk),  8'b010);

    // Fill the stack, changing the flags on every push.
    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1; bus.push = 1'b1; step();
    chk("push1_flags", 8'(nzvc), 8'b1010);
    chk("push1_stk",   8'(stk),  8'b000);
    op(ALU_SUB, 8'h05, 8'h05, 8'h00, 1'b1); bus.setF = 1'b1; bus.push = 1'b1; step();
    op(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b1); bus.setF = 1'b1; bus.push = 1'b1; step();
    op(ALU_CMP, 8'h01, 8'h02, 8'hFF, 1'b0); bus.setF = 1'b1; bus.push = 1'b1; step();
    chk("push4_flags", 8'(nzvc), 8'b1000);
    chk("push4_full",  8'(stk),  8'b100);

    bus.push = 1'b1; step();
    chk("push5_err",   8'(stk),  8'b101);
    chk("push5_flags", 8'(nzvc), 8'b1000);

    bus.pop = 1'b1; step();
    chk("pop1_flags", 8'(nzvc), 8'b0011);
    chk("pop1_stk",   8'(stk),  8'b001);

    bus.push = 1'b1; bus.pop = 1'b1; step();
    chk("pushpop_flags", 8'(nzvc), 8'b0011);
    chk("pushpop_stk",   8'(stk),  8'b001);

    bus.pop = 1'b1; step();
    chk("pop2_flags", 8'(nzvc), 8'b0101);
    bus.pop = 1'b1; step();
    chk("pop3_flags", 8'(nzvc), 8'b1010);
    bus.pop = 1'b1; step();
    chk("pop4_flags", 8'(nzvc), 8'b0111);
    chk("pop4_empty", 8'(stk),  8'b011);

    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1; bus.pop = 1'b1; step();
    chk("pop_empty_flags", 8'(nzvc), 8'b0111);
    chk("pop_empty_stk",   8'(stk),  8'b011);

    rst = 1'b1;
    #1;
    chk("async_rst_nzvc", 8'(nzvc), 8'b0000);
    chk("async_rst_stk",  8'(stk),  8'b010);
    step();
    rst = 1'b0;
    step();

    op(ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0); bus.setF = 1'b1; step();
    chk("pre_save_flags", 8'(nzvc), 8'b1010);
    op(ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1); bus.setF = 1'b1; bus.push = 1'b1; step();
    chk("push_setf_flags", 8'(nzvc), 8'b0101);
    chk("push_setf_stk",   8'(stk),  8'b000);
    op(ALU_SUB, 8'h80, 8'h01, 8'h7F, 1'b1); bus.setF = 1'b1; bus.pop = 1'b1; step();
    chk("pop_setf_flags", 8'(nzvc), 8'b1010);
    chk("pop_setf_stk",   8'(stk),  8'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
